// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
package seg_pkg;
  localparam int DIG_W = 6;

  localparam logic [4:0] SEG_ALL   = 5'd16;
  localparam logic [4:0] SEG_MINUS = 5'd17;
  localparam logic [4:0] SEG_UNDER = 5'd18;
  localparam logic [4:0] SEG_S     = 5'd19;
  localparam logic [4:0] SEG_G     = 5'd20;
  localparam logic [4:0] SEG_H     = 5'd21;
  localparam logic [4:0] SEG_L     = 5'd22;
  localparam logic [4:0] SEG_RTICK = 5'd23;
  localparam logic [4:0] SEG_LTICK = 5'd24;
  localparam logic [4:0] SEG_BLANK = 5'd31;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_ON    = 1'b1
  } phase_t;
endpackage

// File: rtl/hexdigit.sv
// Combinational glyph decoder: 5-bit code plus dp to active-low {g,f,e,d,c,b,a,dp}.
module hexdigit
  import seg_pkg::*;
(
  input  logic [4:0] in,
  input  logic       dp,
  output logic [7:0] out
);
  always_comb begin
    out = SEG_OFF;
    case (in)
      5'd0:      out = {7'h40, ~dp};
      5'd1:      out = {7'h79, ~dp};
      5'd2:      out = {7'h24, ~dp};
      5'd3:      out = {7'h30, ~dp};
      5'd4:      out = {7'h19, ~dp};
      5'd5:      out = {7'h12, ~dp};
      5'd6:      out = {7'h02, ~dp};
      5'd7:      out = {7'h78, ~dp};
      5'd8:      out = {7'h00, ~dp};
      5'd9:      out = {7'h10, ~dp};
      5'd10:     out = {7'h08, ~dp};
      5'd11:     out = {7'h03, ~dp};
      5'd12:     out = {7'h46, ~dp};
      5'd13:     out = {7'h21, ~dp};
      5'd14:     out = {7'h06, ~dp};
      5'd15:     out = {7'h0E, ~dp};
      SEG_ALL:   out = 8'h00;
      SEG_MINUS: out = 8'h7F;
      SEG_UNDER: out = 8'hEF;
      SEG_S:     out = 8'h25;
      SEG_G:     out = 8'h05;
      SEG_H:     out = 8'h13;
      SEG_L:     out = 8'h8F;
      SEG_RTICK: out = 8'hFB;
      SEG_LTICK: out = 8'hBF;
      default:   out = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/seg_scan_timer.sv
// BLANK/ON phase sequencer: cycles every digit slot and flags the last ON cycle of a frame.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int ON_CYC     = 12000,
  parameter int BLANK_CYC  = 64,
  localparam int IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int MAX_CYC   = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC,
  localparam int CW        = $clog2(MAX_CYC + 1)
) (
  input  logic          clk,
  input  logic          rst,
  output phase_t        phase,
  output logic [IW-1:0] idx,
  output logic          boundary
);
  phase_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic          blank_end, on_end, last_digit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= PH_BLANK;
      cnt_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
    end
  end

  assign blank_end  = (cnt_reg == CW'(BLANK_CYC - 1));
  assign on_end     = (cnt_reg == CW'(ON_CYC - 1));
  assign last_digit = (idx_reg == IW'(NUM_DIGITS - 1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    idx_next   = idx_reg;
    case (state_reg)
      PH_BLANK: begin
        if (blank_end) begin
          state_next = PH_ON;
          cnt_next   = '0;
        end
      end
      PH_ON: begin
        if (on_end) begin
          state_next = PH_BLANK;
          cnt_next   = '0;
          idx_next   = last_digit ? '0 : idx_reg + 1'b1;
        end
      end
      default: begin
        state_next = PH_BLANK;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    phase    = state_reg;
    idx      = idx_reg;
    boundary = (state_reg == PH_ON) && on_end && last_digit;
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Double-buffered scan controller for a common-anode multi-digit 7-segment display.
// Optional leading-zero suppression is compiled in with SEG_LZ_BLANK_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int ON_CYC     = 12000,
  parameter int BLANK_CYC  = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DIG_W*NUM_DIGITS-1:0] frame_in,
  input  logic                        load_valid,
  output logic                        load_ready,
  output logic [7:0]                  seg_out,
  output logic [NUM_DIGITS-1:0]       dig_en,
  output logic                        frame_done
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  phase_t                      phase;
  logic [IW-1:0]               idx;
  logic                        boundary;
  logic [DIG_W*NUM_DIGITS-1:0] pending_reg;
  logic                        pending_full_reg;
  logic [DIG_W*NUM_DIGITS-1:0] active_reg;
  logic [DIG_W-1:0]            digit [NUM_DIGITS];
  logic [DIG_W-1:0]            cur;
  logic [4:0]                  dec_code;
  logic                        dec_dp;
  logic [7:0]                  dec_seg;
  logic [7:0]                  seg_reg;
  logic [NUM_DIGITS-1:0]       dig_en_reg;

  seg_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .ON_CYC     (ON_CYC),
    .BLANK_CYC  (BLANK_CYC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .phase    (phase),
    .idx      (idx),
    .boundary (boundary)
  );

  assign load_ready = ~pending_full_reg;
  assign frame_done = boundary;

  // A load can only land while pending is empty, and the frame swap only fires
  // while it is full, so the two never collide on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg      <= '0;
      pending_full_reg <= 1'b0;
      active_reg       <= {NUM_DIGITS{{1'b0, SEG_BLANK}}};
    end else if (boundary && pending_full_reg) begin
      active_reg       <= pending_reg;
      pending_full_reg <= 1'b0;
    end else if (load_valid && !pending_full_reg) begin
      pending_reg      <= frame_in;
      pending_full_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit[gi] = active_reg[gi*DIG_W +: DIG_W];
  end

  assign cur = digit[idx];

`ifdef SEG_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] is_zero;
  logic [NUM_DIGITS-1:0] lz_mask;

  // Suppression runs from the top digit down and stops at the first non-zero one.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
    assign is_zero[gi] = (digit[gi] == '0);
    if (gi == 0) begin : g_lsd
      assign lz_mask[gi] = 1'b0;
    end else if (gi == NUM_DIGITS - 1) begin : g_msd
      assign lz_mask[gi] = is_zero[gi];
    end else begin : g_mid
      assign lz_mask[gi] = is_zero[gi] & lz_mask[gi+1];
    end
  end

  assign dec_code = lz_mask[idx] ? SEG_BLANK : cur[4:0];
  assign dec_dp   = lz_mask[idx] ? 1'b0 : cur[5];
`else
  assign dec_code = cur[4:0];
  assign dec_dp   = cur[5];
`endif

  hexdigit u_dec (
    .in  (dec_code),
    .dp  (dec_dp),
    .out (dec_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_reg    <= SEG_OFF;
      dig_en_reg <= '1;
    end else if (phase == PH_ON) begin
      seg_reg    <= dec_seg;
      dig_en_reg <= ~(NUM_DIGITS'(1) << idx);
    end else begin
      seg_reg    <= SEG_OFF;
      dig_en_reg <= '1;
    end
  end

  assign seg_out = seg_reg;
  assign dig_en  = dig_en_reg;
endmodule
